// File: rtl/sfft_frame_loader.sv
// sfft_frame_loader: ping-pong buffer assembling streamed complex samples into 64-sample frames for the SFFT.
// One bank fills while the other is presented; framing errors pulse sync_err.
module sfft_frame_loader #(
   parameter int W = 12,
   parameter int N = 64
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           s_valid,
   output logic           s_ready,
   input  logic [W-1:0]   s_real,
   input  logic [W-1:0]   s_imag,
   input  logic           s_last,
   output logic           frame_valid,
   input  logic           frame_ack,
   output logic [N*W-1:0] frame_r,
   output logic [N*W-1:0] frame_i,
   output logic           sync_err,
   output logic [15:0]    frame_cnt
);
   logic [W-1:0] mem_r [2][N];
   logic [W-1:0] mem_i [2][N];
   logic [1:0]   full;
   logic         wr_bank, rd_bank;
   logic [5:0]   wr_idx;
   logic         acc, at_end, ack;
   assign s_ready     = !full[wr_bank];
   assign frame_valid = full[rd_bank];
   assign acc         = s_valid && s_ready;
   assign at_end      = wr_idx == 6'(N-1);
   assign ack         = frame_valid && frame_ack;
   // Bank storage needs no reset; contents are only observed once a frame is full.
   always_ff @(posedge clk) begin
      if (acc) begin
         mem_r[wr_bank][wr_idx] <= s_real;
         mem_i[wr_bank][wr_idx] <= s_imag;
      end
   end
   // Completion and acknowledge never address the same bank: a full write bank blocks acceptance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full      <= '0;
         wr_bank   <= 1'b0;
         rd_bank   <= 1'b0;
         wr_idx    <= '0;
         frame_cnt <= '0;
         sync_err  <= 1'b0;
      end else begin
         if (ack) begin
            full[rd_bank] <= 1'b0;
            rd_bank       <= ~rd_bank;
            frame_cnt     <= frame_cnt + 16'd1;
         end
         if (acc && at_end) begin
            full[wr_bank] <= 1'b1;
            wr_bank       <= ~wr_bank;
         end
         wr_idx   <= acc ? ((at_end || s_last) ? 6'd0 : wr_idx + 6'd1) : wr_idx;
         sync_err <= acc && (at_end != s_last);
      end
   end
   for (genvar k = 0; k < N; k++) begin : g_out
      assign frame_r[W*k +: W] = mem_r[rd_bank][k];
      assign frame_i[W*k +: W] = mem_i[rd_bank][k];
   end
endmodule
